bridge_keypad: RTL and testbench
================================

Name: bridge_keypad

Overview:
- Converts MiSTer PS/2 key events and joystick buttons into the 12-line active-low keypad matrix that feeds the system's `inputs` bus.
- Sits directly upstream of the system top level, clocked by the core clock.
- Applies a per-key minimum hold time counted in video frames, so short taps survive the firmware's PIO row-scan polling.

Parameters:
- HOLD_FRAMES, 3: minimum number of vblank rising edges a key stays reported after a press; legal range 0..15; 0 means pure level behaviour.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- ps2_key  in  11  hps_io key event: [10] toggle strobe, [9] pressed, [8] extended, [7:0] set-2 scancode
- joystick  in  12  active-high button bits, one per key index, same clock domain
- vblank  in  1  vblank from the system, same clock domain
- inputs_n  out  12  active-low key lines; [3:0] row 0, [7:4] row 1, [11:8] row 2
- key_event  out  1  one-cycle pulse for each accepted (mapped) PS/2 event

Behaviour:
- Reset state (asynchronous, active-low; already decided, fixed polarity and synchronicity):
  - inputs_n = 12'hFFF, key_event = 0.
  - All pressed flags and hold counters cleared; toggle_prev = 0; armed = 0.
- Arming:
  - On the first clock edge after reset_n deasserts, toggle_prev loads ps2_key[10] and armed is set.
  - No event is generated on that edge.
- Event detect:
  - While armed, ps2_key[10] != toggle_prev at a clock edge is an event.
  - toggle_prev updates every edge.
- Decode, registered:
  - Event edge registers the key index and press flag into a decode stage.
  - The key state updates on the following edge.
  - inputs_n therefore reflects a ps2_key change at the 2nd clock edge after the change.
  - key_event pulses in the same cycle as the key-state update.
- Scancode map, non-extended:
  - 16→0, 1E→1, 26→2, 25→3, 2E→4, 36→5, 3D→6, 3E→7, 46→8, 45→9, 5A→10, 66→11.
- Scancode map, extended:
  - E0 5A→10.
  - All other extended codes are ignored.
- Unmapped events are ignored: no state change and no key_event pulse.
- Press event on key k:
  - pressed[k] set; hold[k] loaded with HOLD_FRAMES.
  - A repeated press (typematic) reloads hold[k].
- Release event on key k:
  - pressed[k] cleared; hold[k] continues counting down.
- Frame tick:
  - Defined as the rising edge of vblank: current 1, registered previous value 0.
  - Each nonzero hold counter decrements by 1; counters saturate at 0.
- Simultaneous press load and frame tick on the same key: the load wins (hold = HOLD_FRAMES, not HOLD_FRAMES-1).
  - A tick still decrements all other keys.
- Hold counter width is 4 bits. Only HOLD_FRAMES[3:0] is used.
- Key active:
  - active[k] = pressed[k] | (hold[k] != 0) | joystick_q[k].
  - joystick_q is joystick registered once, giving 1-cycle latency.
  - inputs_n[k] = ~active[k], driven from a register.
  - Total joystick latency is 2 edges.
- Keys are fully independent; any number may be active at once.
- HOLD_FRAMES = 0: the output follows the pressed state only, with no extension.
- A release arriving before any frame tick keeps the key active until hold reaches 0, i.e. for HOLD_FRAMES ticks.
- Reset asserted mid-hold clears everything immediately and asynchronously.
- After reset, re-arming applies, so no stale toggle produces an event.

Test Plan:
- Reset with ps2_key[10]=1 held, then release reset → inputs_n=FFF, no key_event, including for 5 cycles after.
- Toggle ps2_key with {pressed=1, ext=0, code=16} → inputs_n[0]=0 at the 2nd edge, key_event pulses once. Then release code 16 with no vblank → inputs_n[0] stays 0. After 3 vblank rising edges, inputs_n[0]=1 on the edge of the 3rd tick.
- HOLD_FRAMES=0: press then release 5A → inputs_n[10] low only between the press and release updates. Extended E0 5A behaves identically. Extended E0 16 → no change, no key_event.
- Press 1E on the same edge as a vblank rising edge → hold[1]=3 after that edge (load wins). Concurrently, key 2 with hold=2 → 1.
- joystick=12'h801 for 1 cycle with no PS/2 activity → inputs_n=12'h7FE for exactly 1 cycle, starting at the 2nd edge. Concurrent press on key 0 → OR'd behaviour, and key 0 stays low after the joystick drops.
- Assert reset_n=0 asynchronously while keys 3 and 7 are held with nonzero hold → inputs_n=FFF immediately, before the next clock edge.

Source files
------------

// File: rtl/bridge_keypad.sv
// PS/2 key events and joystick buttons to the 12-line active-low keypad matrix.
// Each key press stays reported for at least HOLD_FRAMES vblank rising edges.
module bridge_keypad #(
    parameter int unsigned HOLD_FRAMES = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [11:0] joystick,
    input  logic        vblank,
    output logic [11:0] inputs_n,
    output logic        key_event
);

    localparam logic [3:0] HOLD_LOAD = HOLD_FRAMES[3:0];

    logic        toggle_prev;
    logic        armed;
    logic        vblank_prev;
    logic        dec_valid;
    logic        dec_press;
    logic [3:0]  dec_idx;
    logic [11:0] pressed;
    logic [3:0]  hold [12];
    logic [11:0] joystick_q;

    logic        event_now;
    logic        tick;
    logic [4:0]  map;
    logic [11:0] pressed_nx;
    logic [3:0]  hold_nx [12];
    logic [11:0] active_nx;

    // Returns {mapped, key index}
    function automatic logic [4:0] map_code(input logic ext, input logic [7:0] code);
        logic [4:0] r;
        r = 5'd0;
        if (ext) begin
            if (code == 8'h5A) r = {1'b1, 4'd10};
        end else begin
            case (code)
                8'h16:   r = {1'b1, 4'd0};
                8'h1E:   r = {1'b1, 4'd1};
                8'h26:   r = {1'b1, 4'd2};
                8'h25:   r = {1'b1, 4'd3};
                8'h2E:   r = {1'b1, 4'd4};
                8'h36:   r = {1'b1, 4'd5};
                8'h3D:   r = {1'b1, 4'd6};
                8'h3E:   r = {1'b1, 4'd7};
                8'h46:   r = {1'b1, 4'd8};
                8'h45:   r = {1'b1, 4'd9};
                8'h5A:   r = {1'b1, 4'd10};
                8'h66:   r = {1'b1, 4'd11};
                default: r = 5'd0;
            endcase
        end
        return r;
    endfunction

    assign event_now = armed & (ps2_key[10] ^ toggle_prev);
    assign tick      = vblank & ~vblank_prev;
    assign map       = map_code(ps2_key[8], ps2_key[7:0]);

    // A press load overrides the frame-tick decrement on the same key.
    always_comb begin
        pressed_nx = pressed;
        active_nx  = '0;
        for (int k = 0; k < 12; k++) begin
            hold_nx[k] = hold[k];
            if (tick && hold[k] != 4'd0) hold_nx[k] = hold[k] - 4'd1;
            if (dec_valid && dec_idx == 4'(k)) begin
                pressed_nx[k] = dec_press;
                if (dec_press) hold_nx[k] = HOLD_LOAD;
            end
            active_nx[k] = pressed_nx[k] | (hold_nx[k] != 4'd0) | joystick_q[k];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            toggle_prev <= 1'b0;
            armed       <= 1'b0;
            vblank_prev <= 1'b0;
            dec_valid   <= 1'b0;
            dec_press   <= 1'b0;
            dec_idx     <= 4'd0;
            pressed     <= '0;
            joystick_q  <= '0;
            inputs_n    <= 12'hFFF;
            key_event   <= 1'b0;
            for (int k = 0; k < 12; k++) hold[k] <= 4'd0;
        end else begin
            toggle_prev <= ps2_key[10];
            armed       <= 1'b1;
            vblank_prev <= vblank;
            dec_valid   <= event_now & map[4];
            dec_press   <= ps2_key[9];
            dec_idx     <= map[3:0];
            pressed     <= pressed_nx;
            joystick_q  <= joystick;
            inputs_n    <= ~active_nx;
            key_event   <= dec_valid;
            for (int k = 0; k < 12; k++) hold[k] <= hold_nx[k];
        end
    end

endmodule

// File: tb/tb_bridge_keypad.sv
// Directed bench for bridge_keypad: one instance with HOLD_FRAMES=3 and one with 0,
// both driven by the same stimulus.
module tb_bridge_keypad;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [11:0] joystick;
    logic        vblank;
    logic [11:0] in3, in0;
    logic        ke3, ke0;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    bridge_keypad #(.HOLD_FRAMES(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key), .joystick(joystick),
        .vblank(vblank), .inputs_n(in3), .key_event(ke3)
    );

    bridge_keypad #(.HOLD_FRAMES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key), .joystick(joystick),
        .vblank(vblank), .inputs_n(in0), .key_event(ke0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic ext, input logic prs, input logic [7:0] code);
        ps2_key = {~ps2_key[10], prs, ext, code};
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        ps2_key  = 11'h400;
        joystick = '0;
        vblank   = 1'b0;
        step(); step();
        total++; if (in3 !== 12'hFFF) $display("FAIL reset_in3 got %h exp %h", in3, 12'hFFF); else pass_cnt++;
        total++; if (in0 !== 12'hFFF) $display("FAIL reset_in0 got %h exp %h", in0, 12'hFFF); else pass_cnt++;
        total++; if (ke3 !== 1'b0) $display("FAIL reset_ke3 got %b exp 0", ke3); else pass_cnt++;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            total++; if (ke3 !== 1'b0 || ke0 !== 1'b0) $display("FAIL arm_event cyc %0d got %b%b exp 00", i, ke3, ke0); else pass_cnt++;
            total++; if (in3 !== 12'hFFF) $display("FAIL arm_in3 cyc %0d got %h exp %h", i, in3, 12'hFFF); else pass_cnt++;
        end
    endtask

    task automatic test_press_hold();
        send(1'b0, 1'b1, 8'h16);
        step();
        total++; if (in3 !== 12'hFFF || ke3 !== 1'b0) $display("FAIL press_e1 got %h/%b exp FFF/0", in3, ke3); else pass_cnt++;
        step();
        total++; if (in3 !== 12'hFFE || ke3 !== 1'b1) $display("FAIL press_e2 got %h/%b exp FFE/1", in3, ke3); else pass_cnt++;
        step();
        total++; if (in3 !== 12'hFFE || ke3 !== 1'b0) $display("FAIL press_e3 got %h/%b exp FFE/0", in3, ke3); else pass_cnt++;
        send(1'b0, 1'b0, 8'h16);
        step(); step();
        total++; if (in3 !== 12'hFFE || ke3 !== 1'b1) $display("FAIL release_hold got %h/%b exp FFE/1", in3, ke3); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            vblank = 1'b1;
            step();
            total++;
            if (in3 !== ((i == 2) ? 12'hFFF : 12'hFFE))
                $display("FAIL hold_tick%0d got %h exp %h", i, in3, (i == 2) ? 12'hFFF : 12'hFFE);
            else pass_cnt++;
            vblank = 1'b0;
            step();
        end
    endtask

    task automatic test_hold_zero();
        send(1'b0, 1'b1, 8'h5A);
        step();
        total++; if (in0 !== 12'hFFF) $display("FAIL h0_press_e1 got %h exp FFF", in0); else pass_cnt++;
        step();
        total++; if (in0 !== 12'hBFF || ke0 !== 1'b1) $display("FAIL h0_press_e2 got %h/%b exp BFF/1", in0, ke0); else pass_cnt++;
        step(); step();
        total++; if (in0 !== 12'hBFF) $display("FAIL h0_held got %h exp BFF", in0); else pass_cnt++;
        send(1'b0, 1'b0, 8'h5A);
        step();
        total++; if (in0 !== 12'hBFF) $display("FAIL h0_rel_e1 got %h exp BFF", in0); else pass_cnt++;
        step();
        total++; if (in0 !== 12'hFFF || ke0 !== 1'b1) $display("FAIL h0_rel_e2 got %h/%b exp FFF/1", in0, ke0); else pass_cnt++;
        send(1'b1, 1'b1, 8'h5A);
        step(); step();
        total++; if (in0 !== 12'hBFF || ke0 !== 1'b1) $display("FAIL h0_ext_press got %h/%b exp BFF/1", in0, ke0); else pass_cnt++;
        send(1'b1, 1'b0, 8'h5A);
        step(); step();
        total++; if (in0 !== 12'hFFF) $display("FAIL h0_ext_rel got %h exp FFF", in0); else pass_cnt++;
        send(1'b1, 1'b1, 8'h16);
        step();
        total++; if (ke0 !== 1'b0) $display("FAIL ext_unmapped_e1 got %b exp 0", ke0); else pass_cnt++;
        step();
        total++; if (ke0 !== 1'b0 || ke3 !== 1'b0 || in0 !== 12'hFFF) $display("FAIL ext_unmapped_e2 got %b%b/%h exp 00/FFF", ke0, ke3, in0); else pass_cnt++;
        step();
        total++; if (ke0 !== 1'b0) $display("FAIL ext_unmapped_e3 got %b exp 0", ke0); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            vblank = 1'b1; step();
            vblank = 1'b0; step();
        end
        total++; if (in3 !== 12'hFFF) $display("FAIL h3_cleanup got %h exp FFF", in3); else pass_cnt++;
    endtask

    task automatic test_load_wins();
        send(1'b0, 1'b1, 8'h26); step(); step();
        send(1'b0, 1'b0, 8'h26); step(); step();
        total++; if (in3 !== 12'hFFB) $display("FAIL lw_key2_hold got %h exp FFB", in3); else pass_cnt++;
        vblank = 1'b1; step();
        vblank = 1'b0; step();
        send(1'b0, 1'b1, 8'h1E);
        step();
        vblank = 1'b1;
        step();
        total++; if (in3 !== 12'hFF9 || ke3 !== 1'b1) $display("FAIL lw_same_edge got %h/%b exp FF9/1", in3, ke3); else pass_cnt++;
        vblank = 1'b0;
        send(1'b0, 1'b0, 8'h1E);
        step(); step();
        total++; if (in3 !== 12'hFF9) $display("FAIL lw_released got %h exp FF9", in3); else pass_cnt++;
        vblank = 1'b1; step();
        total++; if (in3 !== 12'hFFD) $display("FAIL lw_tick1 got %h exp FFD", in3); else pass_cnt++;
        vblank = 1'b0; step();
        vblank = 1'b1; step();
        total++; if (in3 !== 12'hFFD) $display("FAIL lw_tick2 got %h exp FFD", in3); else pass_cnt++;
        vblank = 1'b0; step();
        vblank = 1'b1; step();
        total++; if (in3 !== 12'hFFF) $display("FAIL lw_tick3 got %h exp FFF", in3); else pass_cnt++;
        vblank = 1'b0; step();
    endtask

    task automatic test_joystick();
        joystick = 12'h801;
        step();
        joystick = '0;
        total++; if (in3 !== 12'hFFF) $display("FAIL joy_e1 got %h exp FFF", in3); else pass_cnt++;
        step();
        total++; if (in3 !== 12'h7FE) $display("FAIL joy_e2 got %h exp 7FE", in3); else pass_cnt++;
        step();
        total++; if (in3 !== 12'hFFF) $display("FAIL joy_e3 got %h exp FFF", in3); else pass_cnt++;
        send(1'b0, 1'b1, 8'h16);
        joystick = 12'h801;
        step();
        joystick = '0;
        total++; if (in3 !== 12'hFFF) $display("FAIL joykey_e1 got %h exp FFF", in3); else pass_cnt++;
        step();
        total++; if (in3 !== 12'h7FE || ke3 !== 1'b1) $display("FAIL joykey_e2 got %h/%b exp 7FE/1", in3, ke3); else pass_cnt++;
        step();
        total++; if (in3 !== 12'hFFE) $display("FAIL joykey_e3 got %h exp FFE", in3); else pass_cnt++;
        send(1'b0, 1'b0, 8'h16); step(); step();
        for (int i = 0; i < 3; i++) begin
            vblank = 1'b1; step();
            vblank = 1'b0; step();
        end
        total++; if (in3 !== 12'hFFF) $display("FAIL joy_cleanup got %h exp FFF", in3); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        send(1'b0, 1'b1, 8'h25); step(); step();
        send(1'b0, 1'b1, 8'h3E); step(); step();
        send(1'b0, 1'b0, 8'h25); step(); step();
        total++; if (in3 !== 12'hF77) $display("FAIL ar_before got %h exp F77", in3); else pass_cnt++;
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (in3 !== 12'hFFF) $display("FAIL ar_async_in3 got %h exp FFF", in3); else pass_cnt++;
        total++; if (in0 !== 12'hFFF || ke3 !== 1'b0) $display("FAIL ar_async_in0 got %h/%b exp FFF/0", in0, ke3); else pass_cnt++;
        step();
        send(1'b0, 1'b1, 8'h16);
        step();
        reset_n = 1'b1;
        step();
        total++; if (ke3 !== 1'b0) $display("FAIL rearm_e1 got %b exp 0", ke3); else pass_cnt++;
        step(); step();
        total++; if (ke3 !== 1'b0 || in3 !== 12'hFFF) $display("FAIL rearm_stale got %b/%h exp 0/FFF", ke3, in3); else pass_cnt++;
        send(1'b0, 1'b1, 8'h1E);
        step(); step();
        total++; if (ke3 !== 1'b1 || in3 !== 12'hFFD) $display("FAIL rearm_event got %b/%h exp 1/FFD", ke3, in3); else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed %0d total %0d", pass_cnt, total);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_press_hold();
        test_hold_zero();
        test_load_wins();
        test_joystick();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
